// File: rtl/mdu_arbiter_pkg.sv
// Shared definitions for the MDU arbiter: op-field layout, FSM encoding, defaults.
package mdu_arbiter_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned OP_W      = 5;

  // Bit positions inside the 5-bit request op; sgn spans [OP_SGN+1:OP_SGN]
  localparam int unsigned OP_DIV  = 4;
  localparam int unsigned OP_SEL  = 3;
  localparam int unsigned OP_WORD = 2;
  localparam int unsigned OP_SGN  = 0;

  // Same layout as a packed struct; sel = high half for mul, remainder for div
  typedef struct packed {
    logic       div;
    logic       sel;
    logic       word;
    logic [1:0] sgn;
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_arbiter_fmt.sv
// mdu_fmt: combinational operand preparation (for issue) and result formatting
// (for the response).
//   i_prep_op, i_a, i_b        : op and raw operands of the request being granted
//   o_a, o_b                   : operands as presented to the unit
//   i_fmt_op                   : op of the operation in flight
//   i_mul_hi/lo, i_quo, i_rem  : unit results
//   o_res                      : formatted result
module mdu_fmt
  import mdu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  mdu_op_t          i_prep_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  output logic [XLEN-1:0]  o_a,
  output logic [XLEN-1:0]  o_b,
  input  mdu_op_t          i_fmt_op,
  input  logic [XLEN-1:0]  i_mul_hi,
  input  logic [XLEN-1:0]  i_mul_lo,
  input  logic [XLEN-1:0]  i_quo,
  input  logic [XLEN-1:0]  i_rem,
  output logic [XLEN-1:0]  o_res
);

  // Extend the low word to XLEN, sign- or zero-filled
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
    return {{(XLEN-32){sgn & x[31]}}, x[31:0]};
  endfunction

  logic [XLEN-1:0] w_div_pick;

  // Word divides operate on the low 32 bits only; everything else passes through
  always_comb begin
    o_a = i_a;
    o_b = i_b;
    if (i_prep_op.div && i_prep_op.word) begin
      o_a = ext32(i_a, i_prep_op.sgn[0]);
      o_b = ext32(i_b, i_prep_op.sgn[0]);
    end
  end

  // Word results are always sign-extended from bit 31
  always_comb begin
    o_res      = '0;
    w_div_pick = i_fmt_op.sel ? i_rem : i_quo;
    if (i_fmt_op.div) begin
      o_res = i_fmt_op.word ? ext32(w_div_pick, 1'b1) : w_div_pick;
    end else if (i_fmt_op.word) begin
      o_res = ext32(i_mul_lo, 1'b1);
    end else begin
      o_res = i_fmt_op.sel ? i_mul_hi : i_mul_lo;
    end
  end

endmodule

// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one multiplier and one divider between two requesters
// (r0 = EX pipe, r1 = AMO/aux). One op in flight; round-robin on contention.
//   clk, rst_n                  : clock, async active-low reset
//   flush_flag                  : aborts everything, mirrored on unit_flush
//   rN_req_*                    : request channel (valid/ready, op, a, b, tag)
//   rN_resp_*                   : response channel (valid/ready, data, tag)
//   mul_valid/div_valid         : one-cycle issue pulses
//   unit_signed, unit_a, unit_b : registered operands for the units
//   mul_result_*, quotient, remainder, *_o_valid/_o_ready : unit results
module mdu_arbiter
  import mdu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_flag,
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [OP_W-1:0]  r0_op,
  input  logic [XLEN-1:0]  r0_a,
  input  logic [XLEN-1:0]  r0_b,
  input  logic [TAG_W-1:0] r0_tag,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [XLEN-1:0]  r0_resp_data,
  output logic [TAG_W-1:0] r0_resp_tag,
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [OP_W-1:0]  r1_op,
  input  logic [XLEN-1:0]  r1_a,
  input  logic [XLEN-1:0]  r1_b,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [XLEN-1:0]  r1_resp_data,
  output logic [TAG_W-1:0] r1_resp_tag,
  output logic             unit_flush,
  output logic             mul_valid,
  output logic             div_valid,
  output logic [1:0]       unit_signed,
  output logic [XLEN-1:0]  unit_a,
  output logic [XLEN-1:0]  unit_b,
  input  logic [XLEN-1:0]  mul_result_hi,
  input  logic [XLEN-1:0]  mul_result_lo,
  input  logic [XLEN-1:0]  quotient,
  input  logic [XLEN-1:0]  remainder,
  input  logic             mul_o_valid,
  input  logic             div_o_valid,
  output logic             mul_o_ready,
  output logic             div_o_ready
);

  mdu_state_t       r_state, w_next;
  logic             r_rr_ptr;
  logic             r_owner;
  mdu_op_t          r_op;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_resp_tag;
  logic [XLEN-1:0]  r_unit_a, r_unit_b, r_resp_data;

  logic             w_idle_ok, w_gnt0, w_gnt1, w_gnt, w_done, w_resp_hs;
  mdu_op_t          w_req_op;
  logic [XLEN-1:0]  w_req_a, w_req_b, w_prep_a, w_prep_b, w_res;

  // Arbitration: sole requester wins, rr_ptr breaks ties; never during a flush
  assign w_idle_ok = (r_state == ST_IDLE) && !flush_flag;
  assign w_gnt0    = w_idle_ok && r0_req_valid && (!r1_req_valid || !r_rr_ptr);
  assign w_gnt1    = w_idle_ok && r1_req_valid && (!r0_req_valid ||  r_rr_ptr);
  assign w_gnt     = w_gnt0 || w_gnt1;

  assign w_req_op  = w_gnt1 ? mdu_op_t'(r1_op) : mdu_op_t'(r0_op);
  assign w_req_a   = w_gnt1 ? r1_a : r0_a;
  assign w_req_b   = w_gnt1 ? r1_b : r0_b;

  // Completion and response handshakes; flush overrides both
  assign w_done    = (r_state == ST_WAIT) && !flush_flag &&
                     (r_op.div ? div_o_valid : mul_o_valid);
  assign w_resp_hs = (r_state == ST_RESP) && !flush_flag &&
                     (r_owner ? r1_resp_ready : r0_resp_ready);

  mdu_fmt #(.XLEN(XLEN)) u_fmt (
    .i_prep_op (w_req_op),
    .i_a       (w_req_a),
    .i_b       (w_req_b),
    .o_a       (w_prep_a),
    .o_b       (w_prep_b),
    .i_fmt_op  (r_op),
    .i_mul_hi  (mul_result_hi),
    .i_mul_lo  (mul_result_lo),
    .i_quo     (quotient),
    .i_rem     (remainder),
    .o_res     (w_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (flush_flag) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_gnt)     w_next = ST_ISSUE;
        ST_ISSUE:                w_next = ST_WAIT;
        ST_WAIT:  if (w_done)    w_next = ST_RESP;
        ST_RESP:  if (w_resp_hs) w_next = ST_IDLE;
        default:                 w_next = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs, decoded from state and the latched op
  always_comb begin
    r0_req_ready  = w_gnt0;
    r1_req_ready  = w_gnt1;
    mul_valid     = 1'b0;
    div_valid     = 1'b0;
    mul_o_ready   = 1'b0;
    div_o_ready   = 1'b0;
    r0_resp_valid = 1'b0;
    r1_resp_valid = 1'b0;
    if (!flush_flag) begin
      mul_valid   = (r_state == ST_ISSUE) && !r_op.div;
      div_valid   = (r_state == ST_ISSUE) &&  r_op.div;
      mul_o_ready = (r_state == ST_WAIT)  && !r_op.div;
      div_o_ready = (r_state == ST_WAIT)  &&  r_op.div;
    end
    r0_resp_valid = (r_state == ST_RESP) && !r_owner;
    r1_resp_valid = (r_state == ST_RESP) &&  r_owner;
  end

  // Request capture, result capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_op        <= '0;
      r_tag       <= '0;
      r_unit_a    <= '0;
      r_unit_b    <= '0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
    end else begin
      if (w_gnt) begin
        r_owner  <= w_gnt1;
        r_op     <= w_req_op;
        r_tag    <= w_gnt1 ? r1_tag : r0_tag;
        r_unit_a <= w_prep_a;
        r_unit_b <= w_prep_b;
      end
      if (w_done) begin
        r_resp_data <= w_res;
        r_resp_tag  <= r_tag;
      end
      if (w_resp_hs) r_rr_ptr <= ~r_owner;
    end
  end

  assign unit_flush   = flush_flag;
  assign unit_signed  = r_op.sgn;
  assign unit_a       = r_unit_a;
  assign unit_b       = r_unit_b;
  assign r0_resp_data = r_resp_data;
  assign r1_resp_data = r_resp_data;
  assign r0_resp_tag  = r_resp_tag;
  assign r1_resp_tag  = r_resp_tag;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter. Behavioural mul/div units answer issues after
// a fixed latency. Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_mdu_arbiter;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TAG_W   = 4;
  localparam int          MUL_LAT = 1;
  localparam int          DIV_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_flag;
  logic             r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
  logic [4:0]       r0_op;
  logic [XLEN-1:0]  r0_a, r0_b, r0_resp_data;
  logic [TAG_W-1:0] r0_tag, r0_resp_tag;
  logic             r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
  logic [4:0]       r1_op;
  logic [XLEN-1:0]  r1_a, r1_b, r1_resp_data;
  logic [TAG_W-1:0] r1_tag, r1_resp_tag;
  logic             unit_flush, mul_valid, div_valid;
  logic [1:0]       unit_signed;
  logic [XLEN-1:0]  unit_a, unit_b;
  logic [XLEN-1:0]  mul_result_hi, mul_result_lo, quotient, remainder;
  logic             mul_o_valid, div_o_valid, mul_o_ready, div_o_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_flag(flush_flag),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op(r0_op),
    .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r0_resp_data(r0_resp_data), .r0_resp_tag(r0_resp_tag),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op(r1_op),
    .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .r1_resp_data(r1_resp_data), .r1_resp_tag(r1_resp_tag),
    .unit_flush(unit_flush), .mul_valid(mul_valid), .div_valid(div_valid),
    .unit_signed(unit_signed), .unit_a(unit_a), .unit_b(unit_b),
    .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
    .quotient(quotient), .remainder(remainder),
    .mul_o_valid(mul_o_valid), .div_o_valid(div_o_valid),
    .mul_o_ready(mul_o_ready), .div_o_ready(div_o_ready)
  );

  // ---------------- behavioural units ----------------
  function automatic logic [127:0] mul128(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s);
    logic [127:0] ea, eb;
    ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  logic m_busy, d_busy;
  int   m_cnt, d_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; mul_result_hi <= '0; mul_result_lo <= '0;
    end else if (unit_flush) begin
      m_busy <= 1'b0;
    end else if (mul_valid) begin
      m_busy <= 1'b1; m_cnt <= MUL_LAT;
      {mul_result_hi, mul_result_lo} <= mul128(unit_a, unit_b, unit_signed);
    end else if (m_busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (mul_o_ready) m_busy <= 1'b0;
    end
  end
  assign mul_o_valid = m_busy && (m_cnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_busy <= 1'b0; d_cnt <= 0; quotient <= '0; remainder <= '0;
    end else if (unit_flush) begin
      d_busy <= 1'b0;
    end else if (div_valid) begin
      d_busy <= 1'b1; d_cnt <= DIV_LAT;
      if (unit_signed[0]) begin
        quotient  <= $signed(unit_a) / $signed(unit_b);
        remainder <= $signed(unit_a) % $signed(unit_b);
      end else begin
        quotient  <= unit_a / unit_b;
        remainder <= unit_a % unit_b;
      end
    end else if (d_busy) begin
      if (d_cnt != 0) d_cnt <= d_cnt - 1;
      else if (div_o_ready) d_busy <= 1'b0;
    end
  end
  assign div_o_valid = d_busy && (d_cnt == 0);

  // ---------------- stimulus helpers ----------------
  task automatic slot();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush_flag = 1'b0;
    r0_req_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0; r0_tag = '0; r0_resp_ready = 1'b0;
    r1_req_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0; r1_tag = '0; r1_resp_ready = 1'b0;
    slot(); slot();
    rst_n = 1'b1;
    slot(); #1;
  endtask

  // Waits (bounded) for the given requester's resp_valid; returns at a sample point
  task automatic wait_resp(input bit who, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((who ? r1_resp_valid : r0_resp_valid) === 1'b1) begin
        got = 1'b1;
        break;
      end
      slot(); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if ({r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_valids got=%b exp=0000", {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}); end
    total++; if ({mul_valid, div_valid, mul_o_ready, div_o_ready, unit_flush} !== 5'b0) begin
      bad++; $display("FAIL reset_unit_ctrl got=%b exp=00000", {mul_valid, div_valid, mul_o_ready, div_o_ready, unit_flush}); end
    total++; if ({unit_a, unit_b, r0_resp_data, r0_resp_tag, unit_signed} !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {unit_a, unit_b, r0_resp_data, r0_resp_tag, unit_signed}); end
  endtask

  task automatic test_mulw();
    bit got;
    do_reset();
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b00111; r0_a = 64'h7FFF_FFFF; r0_b = 64'd2; r0_tag = 4'hA;
    #1;
    total++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      bad++; $display("FAIL mulw_grant got=%b exp=10", {r0_req_ready, r1_req_ready}); end
    slot(); r0_req_valid = 1'b0; #1;
    total++; if ({mul_valid, div_valid} !== 2'b10) begin
      bad++; $display("FAIL mulw_issue got=%b exp=10", {mul_valid, div_valid}); end
    slot(); #1;
    total++; if (mul_valid !== 1'b0) begin
      bad++; $display("FAIL mulw_pulse_width got=%b exp=0", mul_valid); end
    wait_resp(1'b0, got);
    total++; if (!got) begin
      bad++; $display("FAIL mulw_resp_timeout got=0 exp=1"); end
    total++; if (r0_resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      bad++; $display("FAIL mulw_data got=%h exp=fffffffffffffffe", r0_resp_data); end
    total++; if ({r0_resp_tag, r1_resp_valid} !== {4'hA, 1'b0}) begin
      bad++; $display("FAIL mulw_tag got=%h/%b exp=a/0", r0_resp_tag, r1_resp_valid); end
    r0_resp_ready = 1'b1;
    slot(); r0_resp_ready = 1'b0; #1;
    total++; if (r0_resp_valid !== 1'b0) begin
      bad++; $display("FAIL mulw_resp_drop got=%b exp=0", r0_resp_valid); end
  endtask

  task automatic test_divw();
    bit got;
    do_reset();
    slot();
    r1_req_valid = 1'b1; r1_op = 5'b11101; r1_a = 64'h0000_0000_FFFF_FFF9; r1_b = 64'd2; r1_tag = 4'h3;
    #1;
    total++; if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
      bad++; $display("FAIL divw_grant got=%b exp=01", {r0_req_ready, r1_req_ready}); end
    slot(); r1_req_valid = 1'b0; #1;
    total++; if ({mul_valid, div_valid, unit_signed[0]} !== 3'b011) begin
      bad++; $display("FAIL divw_issue got=%b exp=011", {mul_valid, div_valid, unit_signed[0]}); end
    total++; if ({unit_a, unit_b} !== {64'hFFFF_FFFF_FFFF_FFF9, 64'd2}) begin
      bad++; $display("FAIL divw_operands got=%h/%h exp=fffffffffffffff9/2", unit_a, unit_b); end
    wait_resp(1'b1, got);
    total++; if (!got) begin
      bad++; $display("FAIL divw_resp_timeout got=0 exp=1"); end
    total++; if ({r1_resp_data, r1_resp_tag, r0_resp_valid} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 1'b0}) begin
      bad++; $display("FAIL divw_resp got=%h/%h/%b exp=ffffffffffffffff/3/0", r1_resp_data, r1_resp_tag, r0_resp_valid); end
    r1_resp_ready = 1'b1;
    slot(); r1_resp_ready = 1'b0; #1;
  endtask

  task automatic test_round_robin();
    bit got;
    do_reset();
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b00000; r0_a = 64'd3; r0_b = 64'd5; r0_tag = 4'h1;
    r1_req_valid = 1'b1; r1_op = 5'b00000; r1_a = 64'd6; r1_b = 64'd7; r1_tag = 4'h2;
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    #1;
    total++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      bad++; $display("FAIL rr_first got=%b exp=10", {r0_req_ready, r1_req_ready}); end
    wait_resp(1'b0, got);
    total++; if ({got, r0_resp_data, r0_resp_tag} !== {1'b1, 64'd15, 4'h1}) begin
      bad++; $display("FAIL rr_r0_resp got=%b/%h/%h exp=1/f/1", got, r0_resp_data, r0_resp_tag); end
    slot(); #1;
    total++; if ({r0_req_ready, r1_req_ready} !== 2'b01) begin
      bad++; $display("FAIL rr_second got=%b exp=01", {r0_req_ready, r1_req_ready}); end
    wait_resp(1'b1, got);
    total++; if ({got, r1_resp_data, r1_resp_tag} !== {1'b1, 64'd42, 4'h2}) begin
      bad++; $display("FAIL rr_r1_resp got=%b/%h/%h exp=1/2a/2", got, r1_resp_data, r1_resp_tag); end
    slot(); #1;
    total++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
      bad++; $display("FAIL rr_third got=%b exp=10", {r0_req_ready, r1_req_ready}); end
    slot(); r0_req_valid = 1'b0; r1_req_valid = 1'b0; #1;
  endtask

  task automatic test_hold_resp();
    bit got;
    do_reset();
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b01000; r0_a = 64'hFFFF_FFFF_FFFF_FFFF; r0_b = 64'd2; r0_tag = 4'h5;
    r1_req_valid = 1'b1; r1_op = 5'b00000; r1_a = 64'd1; r1_b = 64'd1; r1_tag = 4'hC;
    slot(); r0_req_valid = 1'b0; #1;
    wait_resp(1'b0, got);
    total++; if (!got) begin
      bad++; $display("FAIL hold_resp_timeout got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({r0_resp_valid, r0_resp_data, r0_resp_tag, r1_req_ready, r1_resp_valid} !==
                   {1'b1, 64'd1, 4'h5, 1'b0, 1'b0}) begin
        bad++; $display("FAIL hold_stable[%0d] got=%b/%h/%h/%b/%b exp=1/1/5/0/0", i,
                        r0_resp_valid, r0_resp_data, r0_resp_tag, r1_req_ready, r1_resp_valid); end
      slot(); #1;
    end
    r0_resp_ready = 1'b1;
    slot(); r0_resp_ready = 1'b0; #1;
    total++; if ({r0_resp_valid, r1_req_ready, r0_req_ready} !== 3'b010) begin
      bad++; $display("FAIL hold_release got=%b exp=010", {r0_resp_valid, r1_req_ready, r0_req_ready}); end
    r1_req_valid = 1'b0;
  endtask

  task automatic test_flush();
    bit got;
    do_reset();
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b10000; r0_a = 64'd100; r0_b = 64'd7; r0_tag = 4'h6;
    slot(); r0_req_valid = 1'b0; #1;
    total++; if (div_valid !== 1'b1) begin
      bad++; $display("FAIL flush_issue got=%b exp=1", div_valid); end
    slot();
    flush_flag = 1'b1;
    r0_req_valid = 1'b1; r0_tag = 4'h7; r1_req_valid = 1'b1;
    #1;
    total++; if ({unit_flush, r0_req_ready, r1_req_ready} !== 3'b100) begin
      bad++; $display("FAIL flush_same_cycle got=%b exp=100", {unit_flush, r0_req_ready, r1_req_ready}); end
    slot(); flush_flag = 1'b0; #1;
    total++; if ({unit_flush, r0_resp_valid, r0_req_ready, r1_req_ready} !== 4'b0010) begin
      bad++; $display("FAIL flush_after got=%b exp=0010", {unit_flush, r0_resp_valid, r0_req_ready, r1_req_ready}); end
    slot(); r0_req_valid = 1'b0; r1_req_valid = 1'b0; #1;
    wait_resp(1'b0, got);
    total++; if ({got, r0_resp_data, r0_resp_tag} !== {1'b1, 64'd14, 4'h7}) begin
      bad++; $display("FAIL flush_new_op got=%b/%h/%h exp=1/e/7", got, r0_resp_data, r0_resp_tag); end
    r0_resp_ready = 1'b1;
    slot(); r0_resp_ready = 1'b0; #1;
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b00000; r0_a = 64'd9; r0_b = 64'd9; r0_tag = 4'h8;
    slot(); r0_req_valid = 1'b0; #1;
    wait_resp(1'b0, got);
    total++; if ({got, r0_resp_data} !== {1'b1, 64'd81}) begin
      bad++; $display("FAIL rstmid_pre got=%b/%h exp=1/51", got, r0_resp_data); end
    rst_n = 1'b0;
    #1;
    total++; if ({r0_resp_valid, r1_resp_valid, r0_req_ready, mul_valid, div_valid, mul_o_ready, div_o_ready} !== 7'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=0000000",
                      {r0_resp_valid, r1_resp_valid, r0_req_ready, mul_valid, div_valid, mul_o_ready, div_o_ready}); end
    total++; if ({r0_resp_data, r0_resp_tag, unit_a, unit_b, unit_signed} !== '0) begin
      bad++; $display("FAIL rstmid_data got=%h/%h/%h exp=0/0/0", r0_resp_data, r0_resp_tag, unit_a); end
    slot(); rst_n = 1'b1;
    slot();
    r0_req_valid = 1'b1; r0_op = 5'b01011; r0_a = 64'h8000_0000_0000_0000; r0_b = 64'd2; r0_tag = 4'h9;
    slot(); r0_req_valid = 1'b0; #1;
    wait_resp(1'b0, got);
    total++; if ({got, r0_resp_data, r0_resp_tag} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h9}) begin
      bad++; $display("FAIL rstmid_mulh got=%b/%h/%h exp=1/ffffffffffffffff/9", got, r0_resp_data, r0_resp_tag); end
    r0_resp_ready = 1'b1;
    slot(); r0_resp_ready = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_mulw();
    test_divw();
    test_round_robin();
    test_hold_resp();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_arbiter.md
Name: mdu_arbiter

Overview:
Shares one mulu and one divu instance between two requesters: r0, the EX-stage integer pipe, and r1, the AMO/auxiliary path. The arbiter issues one operation at a time and does the word-mode operand preparation and result formatting. It holds the formatted result until the owning requester accepts it. It sits between the requesters and the multi-cycle units, and it is the only driver of their valid, ready and flush inputs.

Parameters:
XLEN, 64, operand/result width
TAG_W, 4, requester tag width, returned unchanged with the result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_flag  in  1  pipeline flush; aborts everything
rN_req_valid  in  1  request valid (N = 0, 1)
rN_req_ready  out  1  request accepted this cycle
rN_op  in  5  {div, sel(high for mul / rem for div), word, sgn[1:0]}
rN_a, rN_b  in  XLEN  operands
rN_tag  in  TAG_W  request tag
rN_resp_valid  out  1  result valid
rN_resp_ready  in  1  result accepted
rN_resp_data  out  XLEN  formatted result
rN_resp_tag  out  TAG_W  tag of the accepted request
unit_flush  out  1  drives mul_flush and div_flush
mul_valid, div_valid  out  1  one-cycle issue pulse
unit_signed  out  2  mul_signed; div_signed = unit_signed[0]
unit_a, unit_b  out  XLEN  prepared operands (registered)
mul_result_hi, mul_result_lo, quotient, remainder  in  XLEN  unit results
mul_o_valid, div_o_valid  in  1  unit result valid
mul_o_ready, div_o_ready  out  1  unit result consumed

Behaviour:
- Reset: state IDLE, rr_ptr = 0, all valid/ready outputs 0, data/tag registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Grant goes to the valid requester; if both are valid, to the one rr_ptr points at.
  - rN_req_ready = grant, combinationally, and only in IDLE with flush_flag low.
  - On the grant, latch owner, op fields, tag and prepared operands. Next state ISSUE.
- Operand preparation:
  - div with word=1: low 32 bits sign-extended if sgn[0], zero-extended otherwise.
  - All other cases: operands passed unchanged.
- ISSUE: exactly one cycle with mul_valid or div_valid = 1, selected by op.div. Next state WAIT.
- WAIT:
  - mul_o_ready / div_o_ready = 1 for the selected unit only.
  - When its o_valid is high, register the formatted result and go to RESP. The unit sees the handshake completed that cycle.
- Result formatting:
  - mul: word=1 gives sext(lo[31:0]); else sel ? hi : lo.
  - div: pick sel ? remainder : quotient; word=1 gives sext of its low 32 bits.
- RESP:
  - rOwner_resp_valid = 1 and held with stable data/tag until rOwner_resp_ready.
  - On the handshake: rr_ptr = ~owner, state IDLE. The next grant can occur the following cycle.
  - The non-owner's resp_valid is always 0.
- Latency: request accept (cycle 0), ISSUE (1), WAIT of at least 1 cycle plus unit latency, then resp_valid. Minimum request-to-response latency is 3 cycles plus unit latency.
- flush_flag:
  - unit_flush = flush_flag, combinational.
  - In any state, next state is IDLE. The latched op is dropped and no resp_valid is produced for it; a RESP in progress is withdrawn next cycle.
  - rr_ptr is unchanged. Requests presented in a flush cycle are not granted.
- Simultaneous events:
  - flush_flag wins over resp_ready, over o_valid and over a new grant.
  - A requester may hold req_valid during another's operation; it is served next by round-robin.
- Unexpected o_valid from the non-selected unit: ignored and its o_ready stays 0. A unit must never present o_valid unissued.
- Reset mid-operation: asynchronous return to reset values. The units are reset by the same rst_n.

Decomposition:
- Shared package/define file: op-field bit positions (OP_DIV, OP_SEL, OP_WORD, OP_SGN), FSM state encodings, XLEN default.
- One natural sub-module: mdu_fmt, the combinational operand preparation and result formatting, reused by a future single-requester path.

Test Plan:
- r0 MULW a=0x7FFF_FFFF, b=2 → mul_valid pulse one cycle after accept; r0_resp_data = 0xFFFF_FFFF_FFFF_FFFE; tag echoed.
- r1 DIVW signed, a=0x0000_0000_FFFF_FFF9 (-7), b=2, sel=rem → unit_a = 0xFFFF_FFFF_FFFF_FFF9; resp = 0xFFFF_FFFF_FFFF_FFFF.
- Both req_valid at reset → r0 granted first, r1 granted in the cycle after r0's resp handshake; with both still valid, grants alternate r0, r1, r0.
- r0_resp_ready held low 5 cycles in RESP → resp_valid/data/tag stable; r1_req_ready stays 0 throughout.
- flush_flag in WAIT → unit_flush = 1 same cycle; IDLE next cycle; no resp_valid; a new r0 request is accepted the following cycle with rr_ptr unchanged.
- rst_n asserted during RESP → all outputs 0 immediately; after release, a MULH 0x8000_0000_0000_0000 × 2 signed returns 0xFFFF_FFFF_FFFF_FFFF.
